// File: rtl/ver_onehot_mon.sv
// One-hot channel monitor: encodes legal one-hot words into an index FIFO and tracks illegal/overflow events.
// Optional per-channel hit counters are built when VER_ONEHOT_MON_HITCNT_EN is defined.
module ver_onehot_mon #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     ver_clk,
  input  logic                     ver_rst,
  input  logic [7:0]               ver_oh_in,
  input  logic                     ver_oh_vld,
  output logic [2:0]               ver_idx_out,
  output logic                     ver_idx_vld,
  input  logic                     ver_idx_rdy,
  output logic [$clog2(DEPTH):0]   ver_level,
  output logic                     ver_err,
  output logic                     ver_ovf,
  output logic [CNT_W-1:0]         ver_err_cnt,
  input  logic                     ver_clr,
  input  logic [2:0]               ver_cnt_sel,
  output logic [CNT_W-1:0]         ver_cnt_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  function automatic logic [3:0] ones8(input logic [7:0] w);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, w[i]};
    end
    return n;
  endfunction

  function automatic logic [2:0] enc8(input logic [7:0] w);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (w[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  logic [2:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          legal;
  logic          illegal;
  logic [2:0]    enc_idx;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          err_next;
  logic          ovf_next;
  logic [CNT_W-1:0] err_cnt_base;
  logic [CNT_W-1:0] err_cnt_next;

  always_comb begin
    legal   = ver_oh_vld && (ones8(ver_oh_in) == 4'd1);
    illegal = ver_oh_vld && (ones8(ver_oh_in) != 4'd1);
    enc_idx = enc8(ver_oh_in);
    full    = (ver_level == FULL_LVL);
    pop     = ver_idx_vld && ver_idx_rdy;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    push    = legal && (!full || pop);
    drop    = legal && full && !pop;
  end

  // Clear takes effect before any same-cycle event is applied.
  always_comb begin
    err_next     = (ver_clr ? 1'b0 : ver_err) | illegal;
    ovf_next     = (ver_clr ? 1'b0 : ver_ovf) | drop;
    err_cnt_base = ver_clr ? '0 : ver_err_cnt;
    err_cnt_next = err_cnt_base;
    if (illegal && (err_cnt_base != '1)) begin
      err_cnt_next = err_cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge ver_clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_idx;
    end
  end

  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ver_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop) begin
        ver_level <= ver_level + LW'(1);
      end else if (pop && !push) begin
        ver_level <= ver_level - LW'(1);
      end
    end
  end

  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) begin
      ver_err     <= 1'b0;
      ver_ovf     <= 1'b0;
      ver_err_cnt <= '0;
    end else begin
      ver_err     <= err_next;
      ver_ovf     <= ovf_next;
      ver_err_cnt <= err_cnt_next;
    end
  end

  // Head is masked when empty so stale entries never show after reset or drain.
  always_comb begin
    ver_idx_vld = (ver_level != '0);
    ver_idx_out = ver_idx_vld ? mem[rd_ptr] : 3'd0;
  end

`ifdef VER_ONEHOT_MON_HITCNT_EN
  logic [CNT_W-1:0] hit_cnt [8];
  logic [CNT_W-1:0] hit_base;

  always_comb begin
    hit_base = ver_clr ? '0 : hit_cnt[enc_idx];
  end

  always_ff @(posedge ver_clk or posedge ver_rst) begin
    if (ver_rst) begin
      for (int unsigned i = 0; i < 8; i++) begin
        hit_cnt[i] <= '0;
      end
    end else begin
      if (ver_clr) begin
        for (int unsigned i = 0; i < 8; i++) begin
          hit_cnt[i] <= '0;
        end
      end
      // Dropped legal words still count as hits.
      if (legal) begin
        hit_cnt[enc_idx] <= (hit_base == '1) ? hit_base : hit_base + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ver_cnt_out = hit_cnt[ver_cnt_sel];
  end
`else
  logic unused_cnt_sel;

  always_comb begin
    ver_cnt_out    = '0;
    unused_cnt_sel = ^ver_cnt_sel;
  end
`endif

endmodule

// File: tb/tb_ver_onehot_mon.sv
// Randomized bench for ver_onehot_mon against a queue-based behavioural model, plus directed scenarios.
module tb_ver_onehot_mon;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int SAT   = (1 << CNT_W) - 1;
`ifdef VER_ONEHOT_MON_HITCNT_EN
  localparam int HIT1 = 1;
`else
  localparam int HIT1 = 0;
`endif

  logic             ver_clk;
  logic             ver_rst;
  logic [7:0]       ver_oh_in;
  logic             ver_oh_vld;
  logic [2:0]       ver_idx_out;
  logic             ver_idx_vld;
  logic             ver_idx_rdy;
  logic [$clog2(DEPTH):0] ver_level;
  logic             ver_err;
  logic             ver_ovf;
  logic [CNT_W-1:0] ver_err_cnt;
  logic             ver_clr;
  logic [2:0]       ver_cnt_sel;
  logic [CNT_W-1:0] ver_cnt_out;

  ver_onehot_mon #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .ver_clk     (ver_clk),
    .ver_rst     (ver_rst),
    .ver_oh_in   (ver_oh_in),
    .ver_oh_vld  (ver_oh_vld),
    .ver_idx_out (ver_idx_out),
    .ver_idx_vld (ver_idx_vld),
    .ver_idx_rdy (ver_idx_rdy),
    .ver_level   (ver_level),
    .ver_err     (ver_err),
    .ver_ovf     (ver_ovf),
    .ver_err_cnt (ver_err_cnt),
    .ver_clr     (ver_clr),
    .ver_cnt_sel (ver_cnt_sel),
    .ver_cnt_out (ver_cnt_out)
  );

  initial ver_clk = 1'b0;
  always #5 ver_clk = ~ver_clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  int q[$];
  bit m_err;
  bit m_ovf;
  int m_errcnt;
  int m_hit[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_err    = 0;
    m_ovf    = 0;
    m_errcnt = 0;
    for (int i = 0; i < 8; i++) m_hit[i] = 0;
  endfunction

  function automatic void model_step(input logic [7:0] oh, input logic vld,
                                     input logic rdy, input logic clr);
    bit pop;
    bit push;
    int idx;
    pop  = (q.size() > 0) && rdy;
    push = 0;
    idx  = 0;
    if (clr) begin
      m_err    = 0;
      m_ovf    = 0;
      m_errcnt = 0;
      for (int i = 0; i < 8; i++) m_hit[i] = 0;
    end
    if (vld) begin
      if ($countones(oh) == 1) begin
        idx = $clog2(int'(oh));
        if (m_hit[idx] < SAT) m_hit[idx]++;
        if (q.size() < DEPTH || pop) push = 1;
        else m_ovf = 1;
      end else begin
        m_err = 1;
        if (m_errcnt < SAT) m_errcnt++;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) q.push_back(idx);
  endfunction

  function automatic int exp_cnt(input logic [2:0] sel);
`ifdef VER_ONEHOT_MON_HITCNT_EN
    return m_hit[sel];
`else
    return (sel == sel) ? 0 : 0;
`endif
  endfunction

  always @(negedge ver_clk) begin
    if (chk_en) begin
      chk("level",   32'(ver_level),   q.size());
      chk("idx_vld", 32'(ver_idx_vld), (q.size() != 0) ? 1 : 0);
      chk("idx_out", 32'(ver_idx_out), (q.size() != 0) ? q[0] : 0);
      chk("err",     32'(ver_err),     m_err);
      chk("ovf",     32'(ver_ovf),     m_ovf);
      chk("err_cnt", 32'(ver_err_cnt), m_errcnt);
      chk("cnt_out", 32'(ver_cnt_out), exp_cnt(ver_cnt_sel));
    end
  end

  // Drives one cycle of inputs; returns 1 time unit after the sampling edge.
  task automatic cycle(input logic [7:0] oh, input logic vld, input logic rdy,
                       input logic clr = 1'b0, input logic [2:0] sel = 3'd0);
    ver_oh_in   = oh;
    ver_oh_vld  = vld;
    ver_idx_rdy = rdy;
    ver_clr     = clr;
    ver_cnt_sel = sel;
    @(posedge ver_clk);
    model_step(oh, vld, rdy, clr);
    #1;
  endtask

  task automatic rst_mid();
    #1;
    ver_rst    = 1'b1;
    ver_oh_vld = 1'b0;
    ver_clr    = 1'b0;
    model_reset();
    #1;
    chk("rst_level",   32'(ver_level),   0);
    chk("rst_idx_vld", 32'(ver_idx_vld), 0);
    chk("rst_idx_out", 32'(ver_idx_out), 0);
    chk("rst_err",     32'(ver_err),     0);
    chk("rst_ovf",     32'(ver_ovf),     0);
    chk("rst_err_cnt", 32'(ver_err_cnt), 0);
    chk("rst_cnt_out", 32'(ver_cnt_out), 0);
    repeat (2) @(posedge ver_clk);
    #1;
    ver_rst = 1'b0;
  endtask

  initial begin
    int pe[4];
    logic [7:0] w;
    pe = '{1, 2, 3, 5};
    ver_rst     = 1'b1;
    ver_oh_in   = '0;
    ver_oh_vld  = 1'b0;
    ver_idx_rdy = 1'b0;
    ver_clr     = 1'b0;
    ver_cnt_sel = '0;
    model_reset();
    chk_en = 1;
    repeat (2) @(posedge ver_clk);
    #1;
    ver_rst = 1'b0;
    chk("init_level", 32'(ver_level), 0);
    chk("init_vld",   32'(ver_idx_vld), 0);

    // Single legal word, consumer ready.
    cycle(8'h10, 1, 1, 0, 3'd4);
    chk("oh10_idx", 32'(ver_idx_out), 4);
    chk("oh10_vld", 32'(ver_idx_vld), 1);
    chk("oh10_hit", 32'(ver_cnt_out), HIT1);
    cycle(8'h00, 0, 1, 0, 3'd4);
    chk("oh10_empty", 32'(ver_idx_vld), 0);
    chk("oh10_lvl0",  32'(ver_level), 0);

    // Fill without consumer, then overflow.
    cycle(8'h01, 1, 0);
    cycle(8'h02, 1, 0);
    cycle(8'h04, 1, 0);
    cycle(8'h08, 1, 0);
    cycle(8'h80, 1, 0, 0, 3'd7);
    chk("full_level", 32'(ver_level), 4);
    chk("full_ovf",   32'(ver_ovf), 1);
    chk("full_head",  32'(ver_idx_out), 0);
    chk("full_hit7",  32'(ver_cnt_out), HIT1);

    // Push with simultaneous pop at full.
    cycle(8'h20, 1, 1);
    chk("pp_level", 32'(ver_level), 4);
    for (int i = 0; i < 4; i++) begin
      chk("pp_pop", 32'(ver_idx_out), pe[i]);
      cycle(8'h00, 0, 1);
    end
    chk("pp_drained", 32'(ver_level), 0);

    // Illegal words and saturation.
    cycle(8'h00, 1, 1);
    cycle(8'h03, 1, 1);
    chk("ill_err",   32'(ver_err), 1);
    chk("ill_cnt2",  32'(ver_err_cnt), 2);
    chk("ill_level", 32'(ver_level), 0);
    for (int i = 0; i < 300; i++) begin
      w = 8'h03 << (i % 7);
      cycle(w, 1, 1);
    end
    chk("ill_sat", 32'(ver_err_cnt), 255);

    // Clear coinciding with an illegal word.
    cycle(8'h01, 1, 0);
    cycle(8'h02, 1, 0);
    cycle(8'h0C, 1, 0, 1);
    chk("clr_err",   32'(ver_err), 1);
    chk("clr_cnt",   32'(ver_err_cnt), 1);
    chk("clr_ovf",   32'(ver_ovf), 0);
    chk("clr_level", 32'(ver_level), 2);

    // Reset mid-operation with entries in flight.
    cycle(8'h04, 1, 0);
    chk("pre_rst_level", 32'(ver_level), 3);
    rst_mid();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0) w = 8'(1 << $urandom_range(0, 7));
      else w = 8'($urandom);
      cycle(w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 99) == 0), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 399) == 0) rst_mid();
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not complete)");
    $fatal(1, "timeout");
  end

endmodule
